scroll_addr_gen: RTL and testbench
==================================

SCROLL_ADDR_GEN -- requirements
Module: scroll_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 4: address width in bits.
REQ-002 Parameter DEPTH, default 16: number of valid addresses (0..DEPTH-1), 2 <= DEPTH <= 2^ADDR_W.
REQ-003 Parameter TICK_W, default 24: width of the step-period prescaler.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  run/pause; low holds the address.
REQ-007 step_period  input  TICK_W  clk cycles per step, minus one.
REQ-008 dir  input  1  0 = increment (scroll left), 1 = decrement (scroll right).
REQ-009 mode  input  2  00 WRAP, 01 BOUNCE, 10 ONESHOT, 11 reserved (treated as WRAP).
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_addr  input  ADDR_W  address value applied on load.
REQ-012 address  output  ADDR_W  active memory address (registered).
REQ-013 tick  output  1  one-cycle pulse on every address step.
REQ-014 wrapped  output  1  one-cycle pulse on wrap-around or bounce reversal.
REQ-015 done  output  1  high while ONESHOT has reached its end address.

Function
REQ-016 States: IDLE, RUN, DONE; IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->DONE on ONESHOT end; DONE exits only on load or reset.
REQ-017 Prescaler counts 0..step_period in RUN only; at count==step_period, tick=1 that cycle and count returns to 0; step_period=0 gives tick every cycle.
REQ-018 In IDLE and DONE the prescaler is held at 0 and address is held.
REQ-019 Address updates in the cycle after tick is asserted (registered step, one-cycle latency from tick).
REQ-020 Internal direction register cur_dir: loaded from dir on load and on IDLE->RUN; in WRAP/ONESHOT follows dir every cycle; in BOUNCE changes only on reversal or load.
REQ-021 WRAP step: up DEPTH-1 -> 0, down 0 -> DEPTH-1, with wrapped=1 coincident with that tick; otherwise +/-1.
REQ-022 BOUNCE step: at DEPTH-1 going up -> DEPTH-2 and cur_dir flips to down; at 0 going down -> 1 and cur_dir flips to up; wrapped=1 on each flip.
REQ-023 ONESHOT: tick at DEPTH-1 (up) or 0 (down) does not move the address; FSM enters DONE, done=1 next cycle, wrapped stays 0.
REQ-024 load has priority over stepping: address <= load_addr, clamped to DEPTH-1 if load_addr >= DEPTH; prescaler cleared; done cleared; next state RUN if enable=1 else IDLE; no tick or wrapped that cycle.
REQ-025 Change of mode while in RUN takes effect at the next tick; change to non-ONESHOT does not exit DONE.
REQ-026 Change of step_period mid-count: compare uses the current value; if count already exceeds new value, count continues to 2^TICK_W-1 then wraps to 0 with no tick.
REQ-027 Arithmetic performed in ADDR_W bits; address never leaves 0..DEPTH-1.

Reset
REQ-028 reset=1 asynchronously forces address=0, prescaler=0, cur_dir=0, state IDLE, tick=0, wrapped=0, done=0.
REQ-029 Reset asserted mid-step discards pending step; after release first tick occurs step_period+1 cycles after enable is sampled high.

Verification
REQ-030 WRAP, dir=0, step_period=0, enable=1 from address 14 -> address 15, 0, 1 on successive cycles; wrapped pulses with the 15->0 tick.
REQ-031 step_period=3, WRAP -> tick every 4th cycle; enable low 10 cycles mid-count -> address frozen, prescaler restarts at 0.
REQ-032 BOUNCE, DEPTH=16, dir=0, start 13 -> 14,15,14,13; wrapped once at 15->14; then start 2 dir=1 -> 1,0,1.
REQ-033 ONESHOT, dir=1, load_addr=2 -> 1,0 then hold 0, done=1; load with load_addr=9 -> done=0, address=9, resumes.
REQ-034 load_addr=20 with ADDR_W=5, DEPTH=16 -> address=15; load and tick in same cycle -> address=load value, no wrapped.
REQ-035 reset pulse mid-run at address 7 -> address=0 immediately (async), done=0, next tick after step_period+1 cycles.

Source files
------------

// File: rtl/scroll_addr_gen.sv
// Scrolling address generator for display memories: a prescaled step clock
// moves an address through 0..DEPTH-1 in wrap, bounce or one-shot fashion.
module scroll_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [TICK_W-1:0] step_period,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] address,
  output logic              tick,
  output logic              wrapped,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOUNCE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TICK_W-1:0] COUNT_ONE = TICK_W'(1);

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cur_dir_q, cur_dir_d;

  logic                step_dir;
  logic                at_end;
  logic                run_step;
  logic                oneshot_end;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   addr_dec;
  logic [ADDR_W-1:0]   load_clamped;

  // Bounce keeps its own heading; the other modes steer straight from dir.
  assign step_dir     = (mode == MODE_BOUNCE) ? cur_dir_q : dir;
  assign at_end       = step_dir ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_LAST);
  assign run_step     = (state_q == ST_RUN) && enable && !load && (count_q == step_period);
  assign oneshot_end  = run_step && (mode == MODE_ONESHOT) && at_end;
  assign addr_inc     = addr_q + ADDR_ONE;
  assign addr_dec     = addr_q - ADDR_ONE;
  assign load_clamped = ({1'b0, load_addr} >= DEPTH_EXT) ? ADDR_LAST : load_addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      cur_dir_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      cur_dir_q <= cur_dir_d;
    end
  end

  // NOTE: each combinational process assigns defaults first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (enable) state_d = ST_RUN;
        ST_RUN: begin
          if (!enable)          state_d = ST_IDLE;
          else if (oneshot_end) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tick    = run_step;
    wrapped = run_step && at_end && (mode != MODE_ONESHOT);
    done    = (state_q == ST_DONE);
  end

  always_comb begin
    count_d   = count_q + COUNT_ONE;
    addr_d    = addr_q;
    cur_dir_d = cur_dir_q;

    // Equality compare only: a count already past a newly lowered period
    // rolls over through the full counter range without ticking.
    if (load || (state_q != ST_RUN) || !enable || (count_q == step_period)) begin
      count_d = '0;
    end

    if (load) begin
      addr_d    = load_clamped;
      cur_dir_d = dir;
    end else begin
      if ((mode != MODE_BOUNCE) || ((state_q == ST_IDLE) && enable)) begin
        cur_dir_d = dir;
      end
      if (run_step) begin
        case (mode)
          MODE_BOUNCE: begin
            if (at_end) begin
              addr_d    = step_dir ? ADDR_ONE : (ADDR_LAST - ADDR_ONE);
              cur_dir_d = ~cur_dir_q;
            end else begin
              addr_d = step_dir ? addr_dec : addr_inc;
            end
          end
          MODE_ONESHOT: begin
            if (!at_end) addr_d = step_dir ? addr_dec : addr_inc;
          end
          default: begin
            if (at_end) addr_d = step_dir ? ADDR_LAST : ADDR_ZERO;
            else        addr_d = step_dir ? addr_dec : addr_inc;
          end
        endcase
      end
    end
  end

  assign address = addr_q;

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Directed bench for scroll_addr_gen: a vector table for single-cycle behaviour
// plus hand-written sequences for prescaler, reset and clamp corner cases.
module tb_scroll_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Default-parameter instance
  logic        enable = 1'b0;
  logic [23:0] step_period = '0;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        load = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [3:0]  address;
  logic        tick, wrapped, done;

  // Wider address, short prescaler instance
  logic        enable2 = 1'b0;
  logic [2:0]  step_period2 = '0;
  logic        dir2 = 1'b0;
  logic [1:0]  mode2 = 2'b00;
  logic        load2 = 1'b0;
  logic [4:0]  load_addr2 = '0;
  logic [4:0]  address2;
  logic        tick2, wrapped2, done2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scroll_addr_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .step_period(step_period),
    .dir(dir), .mode(mode), .load(load), .load_addr(load_addr),
    .address(address), .tick(tick), .wrapped(wrapped), .done(done)
  );

  scroll_addr_gen #(.ADDR_W(5), .DEPTH(16), .TICK_W(3)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .step_period(step_period2),
    .dir(dir2), .mode(mode2), .load(load2), .load_addr(load_addr2),
    .address(address2), .tick(tick2), .wrapped(wrapped2), .done(done2)
  );

  typedef struct {
    logic       ld;
    logic [3:0] la;
    logic       en;
    logic       dr;
    logic [1:0] md;
    logic [3:0] ea;
    logic       et;
    logic       ew;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [3:0] la, input logic en, input logic dr,
                     input logic [1:0] md, input logic [3:0] ea, input logic et,
                     input logic ew, input logic ed);
    vec_t v;
    v.ld = ld; v.la = la; v.en = en; v.dr = dr; v.md = md;
    v.ea = ea; v.et = et; v.ew = ew; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ld la en dr md  | addr tick wrapped done   (step_period = 0)
    add(1, 14, 1, 0, 2'b00,  0, 0, 0, 0);
    add(0,  0, 1, 0, 2'b00, 14, 1, 0, 0);
    add(0,  0, 1, 0, 2'b00, 15, 1, 1, 0);
    add(0,  0, 1, 0, 2'b00,  0, 1, 0, 0);
    add(0,  0, 1, 0, 2'b00,  1, 1, 0, 0);
    add(0,  0, 1, 1, 2'b00,  2, 1, 0, 0);
    add(1, 13, 1, 0, 2'b01,  1, 0, 0, 0);
    add(0,  0, 1, 0, 2'b01, 13, 1, 0, 0);
    add(0,  0, 1, 0, 2'b01, 14, 1, 0, 0);
    add(0,  0, 1, 0, 2'b01, 15, 1, 1, 0);
    add(0,  0, 1, 0, 2'b01, 14, 1, 0, 0);
    add(1,  2, 1, 1, 2'b01, 13, 0, 0, 0);
    add(0,  0, 1, 0, 2'b01,  2, 1, 0, 0);
    add(0,  0, 1, 0, 2'b01,  1, 1, 0, 0);
    add(0,  0, 1, 0, 2'b01,  0, 1, 1, 0);
    add(0,  0, 1, 0, 2'b01,  1, 1, 0, 0);
    add(1,  2, 1, 1, 2'b10,  2, 0, 0, 0);
    add(0,  0, 1, 1, 2'b10,  2, 1, 0, 0);
    add(0,  0, 1, 1, 2'b10,  1, 1, 0, 0);
    add(0,  0, 1, 1, 2'b10,  0, 1, 0, 0);
    add(0,  0, 1, 1, 2'b10,  0, 0, 0, 1);
    add(0,  0, 1, 1, 2'b00,  0, 0, 0, 1);
    add(1,  9, 1, 1, 2'b10,  0, 0, 0, 1);
    add(0,  0, 1, 1, 2'b10,  9, 1, 0, 0);
    add(0,  0, 1, 1, 2'b10,  8, 1, 0, 0);
    add(1, 15, 1, 0, 2'b11,  7, 0, 0, 0);
    add(0,  0, 1, 0, 2'b11, 15, 1, 1, 0);
    add(0,  0, 1, 0, 2'b11,  0, 1, 0, 0);
    add(1, 15, 1, 0, 2'b00,  1, 0, 0, 0);
    add(1,  3, 1, 0, 2'b00, 15, 0, 0, 0);
    add(0,  0, 1, 0, 2'b00,  3, 1, 0, 0);
    add(0,  0, 0, 0, 2'b00,  4, 0, 0, 0);
    add(0,  0, 0, 0, 2'b00,  4, 0, 0, 0);
    add(0,  0, 1, 0, 2'b00,  4, 0, 0, 0);
    add(0,  0, 1, 0, 2'b00,  4, 1, 0, 0);
    add(0,  0, 1, 0, 2'b00,  5, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(address), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; load_addr = vecs[i].la; enable = vecs[i].en;
      dir = vecs[i].dr; mode = vecs[i].md;
      #1;
      check($sformatf("vec%0d_addr", i), 32'(address), 32'(vecs[i].ea));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].et));
      check($sformatf("vec%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].ew));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].ed));
      next_cycle();
    end

    // Prescaler period 3, pause mid-count, restart from zero
    step_period = 24'd3; mode = 2'b00; dir = 1'b0; enable = 1'b1;
    load = 1'b1; load_addr = 4'd0;
    next_cycle();
    load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("p3_tick_k%0d", k), 32'(tick), 32'(k == 3));
      check($sformatf("p3_addr_k%0d", k), 32'(address), (k >= 4) ? 1 : 0);
      next_cycle();
    end
    enable = 1'b0;
    for (int j = 0; j < 10; j++) begin
      #1;
      check($sformatf("pause_tick_j%0d", j), 32'(tick), 0);
      check($sformatf("pause_addr_j%0d", j), 32'(address), 1);
      next_cycle();
    end
    enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      check($sformatf("resume_tick_j%0d", j), 32'(tick), 32'(j == 4));
      check($sformatf("resume_addr_j%0d", j), 32'(address), (j == 5) ? 2 : 1);
      next_cycle();
    end

    // Asynchronous reset mid-step at address 7
    step_period = 24'd2; load = 1'b1; load_addr = 4'd7;
    next_cycle();
    load = 1'b0;
    #1;
    check("pre_rst_addr", 32'(address), 7);
    reset = 1'b1;
    #1;
    check("async_rst_addr", 32'(address), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_tick", 32'(tick), 0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("post_rst_tick_c%0d", c), 32'(tick), 32'(c == 3));
      check($sformatf("post_rst_addr_c%0d", c), 32'(address), (c == 4) ? 1 : 0);
      next_cycle();
    end
    enable = 1'b0;

    // Load clamp with ADDR_W=5, DEPTH=16
    enable2 = 1'b1; mode2 = 2'b00; dir2 = 1'b0; step_period2 = 3'd0;
    load2 = 1'b1; load_addr2 = 5'd20;
    #1;
    check("clamp_load_tick", 32'(tick2), 0);
    next_cycle();
    load2 = 1'b0;
    #1;
    check("clamp20_addr", 32'(address2), 15);
    check("clamp_wrap_tick", 32'(tick2), 1);
    check("clamp_wrap_wrapped", 32'(wrapped2), 1);
    next_cycle();
    #1;
    check("clamp_wrap_addr", 32'(address2), 0);
    load2 = 1'b1; load_addr2 = 5'd16;
    next_cycle();
    #1;
    check("clamp16_addr", 32'(address2), 15);
    load_addr2 = 5'd31;
    next_cycle();
    #1;
    check("clamp31_addr", 32'(address2), 15);
    load_addr2 = 5'd9;
    next_cycle();
    #1;
    check("load9_addr", 32'(address2), 9);

    // Lowering step_period below the running count rolls the counter over
    load_addr2 = 5'd0; step_period2 = 3'd5;
    next_cycle();
    load2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) step_period2 = 3'd1;
      #1;
      check($sformatf("roll_tick_k%0d", k), 32'(tick2), 32'(k == 9));
      check($sformatf("roll_addr_k%0d", k), 32'(address2), 0);
      next_cycle();
    end
    #1;
    check("roll_addr_after", 32'(address2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
